// File: rtl/timer_sched_pkg.sv
// Shared definitions for the interval-timer scheduler: state encodings and
// default widths, used by the RTL and by the verification bench.
package timer_sched_pkg;

    localparam int DEF_N = 4;   // number of requesters
    localparam int DEF_W = 16;  // counter / cycle-value width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request bit found
// when scanning last+1, last+2, ... modulo N. Reusable by any arbiter.
module rr_pick
    import timer_sched_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int LW = $clog2(N);
    // Wide enough to hold last + 1 + (N-1) before the modulo fold.
    localparam int SW = LW + 2;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;
    logic [SW-1:0]  sum;

    // Rotate the request vector so bit 0 is the requester right after last.
    assign dbl = {req, req};
    assign rot = N'(dbl >> (SW'(last) + SW'(1)));

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        valid = |rot;
        off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SW'(j);
            end
        end
        sum = SW'(last) + SW'(1) + off;
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        idx = LW'(sum);
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one countdown interval counter among N requesters. Pending requests
// are served round-robin; the winner owns the counter for exactly its
// requested number of cycles, then gets a one-cycle completion pulse.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       cycles,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         done,
    output logic [$clog2(N)-1:0] cur_id,
    output logic [W-1:0]         remaining,
    output logic                 busy
);

    localparam int LW = $clog2(N);

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]  cur_id_q, cur_id_d;
    logic [LW-1:0]  last_q, last_d;

    logic           pick_valid;
    logic [LW-1:0]  pick_idx;
    logic [W-1:0]   cyc_arr [N];
    logic [W-1:0]   sel_cycles;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Unpack per-requester interval lengths and decode the one-hot outputs
    // purely from registered state, so req/cycles never reach an output.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign cyc_arr[gi] = cycles[gi*W +: W];
            assign grant[gi]   = (state_q == ST_RUN)  && (cur_id_q == LW'(gi));
            assign done[gi]    = (state_q == ST_DONE) && (cur_id_q == LW'(gi));
        end
    endgenerate

    assign sel_cycles = cyc_arr[pick_idx];
    assign cur_id     = cur_id_q;
    assign remaining  = cnt_q;
    assign busy       = (state_q != ST_IDLE);

    // State register; the pointer starts at N-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cur_id_q <= '0;
            last_q   <= LW'(N - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_id_q <= cur_id_d;
            last_q   <= last_d;
        end
    end

    // Next-state: arbitrate in IDLE, count down in RUN, pulse once in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_id_d = cur_id_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cur_id_d = pick_idx;
                    last_d   = pick_idx;
                    cnt_d    = sel_cycles;
                    // A zero-length interval completes without a grant cycle.
                    state_d  = (sel_cycles == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!req[cur_id_q]) begin
                    // Owner withdrew: release silently, no completion pulse.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef FORMAL
    // Per-requester count of intervals handed to others while it waited.
    logic [3:0] skip_q [N];

    generate
        for (gi = 0; gi < N; gi++) begin : g_fv
            // Track how many arbitrations requester gi has lost in a row.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    skip_q[gi] <= '0;
                end else if (!req[gi]) begin
                    skip_q[gi] <= '0;
                end else if (state_q == ST_IDLE && pick_valid) begin
                    skip_q[gi] <= (pick_idx == LW'(gi)) ? 4'd0 : skip_q[gi] + 4'd1;
                end
            end

            a_no_starve: assert property (@(posedge clk) disable iff (reset)
                skip_q[gi] < 4'(N));
            c_done_each: cover property (@(posedge clk) disable iff (reset)
                done[gi]);
        end
    endgenerate

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant));

    a_done_origin: assert property (@(posedge clk) disable iff (reset)
        (|done) |-> ($past(state_q) == ST_RUN) ||
                    ($past(state_q) == ST_IDLE && $past(sel_cycles) == '0));

    a_cnt_monotonic: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_RUN && $past(state_q) == ST_RUN) |-> cnt_q <= $past(cnt_q));
`endif

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one 16-bit countdown interval among N requesters. Arbitrates pending requests round-robin, loads the winner's cycle count, grants exclusive ownership for exactly that many cycles, then signals completion. Sits between per-channel clients (UART timeouts, LED blink, debounce) and the single hardware interval counter.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 16: counter and cycle-value width.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req` input N: per-requester request level; must be held until `done` or abort.
- `cycles` input N*W: requester i's interval length in bits [i*W +: W]; sampled only in the grant cycle.
- `grant` output N: one-hot; bit i high for every cycle of requester i's interval.
- `done` output N: one-cycle pulse on bit i when requester i's interval completes normally.
- `cur_id` output $clog2(N): index of the current or most recent owner.
- `remaining` output W: live counter value.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, counter 0, `grant` 0, `done` 0, `cur_id` 0, `busy` 0, rr pointer `last` = N-1.
- IDLE, no `req` bits: stay in IDLE.
- IDLE, any `req` bit: winner is the first set bit scanning `last`+1, `last`+2, … modulo N. Then `cur_id` <= winner, `last` <= winner, counter <= cycles[winner].
  - cycles ≠ 0: go to RUN.
  - cycles = 0: go to DONE, with no grant cycle.
- RUN: `grant[cur_id]` = 1.
  - `req[cur_id]` low: abort. Counter <= 0, go to IDLE, no `done` pulse.
  - else if counter = 1: counter <= 0, go to DONE.
  - else: counter <= counter - 1.
- DONE: `grant` = 0, `done[cur_id]` = 1 for this single cycle, then go to IDLE.
- Requests from other channels arriving during RUN/DONE stay pending. They are arbitrated in the next IDLE cycle.
- A requester that keeps `req` high after `done` re-enters arbitration. It is lowest priority because `last` points at it.
- Counter never wraps. Decrement happens only in RUN with counter ≥ 2. `cycles` = all-ones gives 2^W-1 grant cycles.
- `cycles` changes outside the grant cycle have no effect.
- `reset` asserted mid-RUN: `grant` and `done` drop asynchronously, and no `done` pulse is emitted.

## Timing
- Request sampled high in IDLE at edge k:
  - `grant` high from after edge k for exactly c cycles.
  - `done` high for the single cycle after `grant` falls.
  - Earliest next grant is 1 cycle after `done`.
- Back-to-back service overhead: 2 cycles per interval (IDLE arbitrate + DONE).
- cycles = 0: `done` pulses the cycle after arbitration, with `grant` never high.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `req` or `cycles` to outputs.
- `remaining` equals c in the first grant cycle and 1 in the last.

## Structure
- Package `timer_sched_pkg`: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default widths. Shared with the verification bench.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req`[N], `last`.
  - Outputs: `valid`, `idx`.
  - Reusable by other arbiters in the design.
- Formal section:
  - `grant` is one-hot-or-zero.
  - `done` implies `$past(grant[cur_id])` or a zero-cycle request.
  - Counter is never greater than `$past(counter)` while in RUN.
  - No requester holding `req` is starved for more than N intervals.
  - Cover: `done` for every index.

## Test plan
- Reset, then `req`=4'b0001, cycles0=5 → `grant`=0001 for 5 cycles, `remaining` 5,4,3,2,1, `done`=0001 one cycle, `busy` falls the cycle after.
- `req`=4'b1111 held, all cycles=2, after reset → grant order 0,1,2,3,0, each for 2 cycles, `done` pulses spaced 4 cycles apart.
- Requester 2 with cycles=0 → `done`=0100 one cycle after arbitration, `grant` never high, `last`=2.
- Requester 1 running cycles=10, drops `req` at `remaining`=6 → `grant` clears next cycle, state IDLE, no `done`.
- `reset` asserted asynchronously mid-RUN (`remaining`=3) → `grant`, `done`, `busy` 0 immediately. After release, `req`=0010 is served first with the `last`=N-1 priority.
- cycles=16'hFFFF on requester 3 → 65535 grant cycles, counter never wraps, single `done` pulse.
